// File: rtl/stepper_seq_driver_if.sv
// Controller <-> stepper driver bundle: move request, status and coil drive.
// Latency: n/a (wires only); all driver-side outputs are registered in the driver.
// Backpressure: none; start_i is only honoured while the driver is idle.
// Ports: start_i/steps_i/dir_i/half_i/abort_i from the controller (master),
//        busy_o/done_o/remaining_o/signal_o back from the driver (slave).
interface stepper_seq_driver_if #(
    parameter int STEPS_W = 16
);
    logic               start_i;
    logic [STEPS_W-1:0] steps_i;
    logic               dir_i;
    logic               half_i;
    logic               abort_i;
    logic               busy_o;
    logic               done_o;
    logic [STEPS_W-1:0] remaining_o;
    logic [3:0]         signal_o;

    modport master (
        output start_i, steps_i, dir_i, half_i, abort_i,
        input  busy_o, done_o, remaining_o, signal_o
    );

    modport slave (
        input  start_i, steps_i, dir_i, half_i, abort_i,
        output busy_o, done_o, remaining_o, signal_o
    );
endinterface

// File: rtl/stepper_seq_driver.sv
// 4-coil stepper sequencer: moves N full/half steps in either direction, one step per STEP_DIV clocks.
// Latency: start -> busy/coils one cycle; N-step move busy for N*STEP_DIV cycles, then one done cycle.
// Backpressure: start_i sampled only in IDLE; abort_i ends a move in RUN on the next cycle.
// Ports: clk, rst_n (async, active low); bus = stepper_seq_driver_if.slave
//        (start/steps/dir/half/abort in; busy/done/remaining/signal out, all registered).
module stepper_seq_driver #(
    parameter int STEPS_W  = 16,
    parameter int STEP_DIV = 10000,
    parameter bit HOLD_EN  = 1'b0
) (
    input logic                 clk,
    input logic                 rst_n,
    stepper_seq_driver_if.slave bus
);
    localparam int DIV_W = $clog2(STEP_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic [2:0]         ph;
    logic [DIV_W-1:0]   div_cnt;
    logic               dir_q;
    logic               half_q;
    logic [STEPS_W-1:0] remaining;
    logic               busy;
    logic               done;
    logic [3:0]         sig;

    logic [2:0]         ph_step;
    logic [2:0]         ph_stepped;

    function automatic logic [3:0] coil(input logic [2:0] idx);
        logic [3:0] c;
        case (idx)
            3'd0:    c = 4'b1000;
            3'd1:    c = 4'b1100;
            3'd2:    c = 4'b0100;
            3'd3:    c = 4'b0110;
            3'd4:    c = 4'b0010;
            3'd5:    c = 4'b0011;
            3'd6:    c = 4'b0001;
            default: c = 4'b1001;
        endcase
        return c;
    endfunction

    // Coil pattern while not running: hold the phase or release all coils.
    function automatic logic [3:0] rest_sig(input logic [2:0] idx);
        return HOLD_EN ? coil(idx) : 4'b0000;
    endfunction

    // 3-bit arithmetic gives the mod-8 wrap for free in both directions.
    always_comb begin
        ph_step    = half_q ? 3'd1 : 3'd2;
        ph_stepped = dir_q ? (ph + ph_step) : (ph - ph_step);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ph        <= 3'd0;
            div_cnt   <= '0;
            dir_q     <= 1'b0;
            half_q    <= 1'b0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sig       <= 4'b0000;
        end else begin
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    sig  <= rest_sig(ph);
                    if (bus.start_i) begin
                        dir_q     <= bus.dir_i;
                        half_q    <= bus.half_i;
                        remaining <= bus.steps_i;
                        div_cnt   <= '0;
                        if (bus.steps_i != '0) begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                            sig   <= coil(ph);
                        end else begin
                            // Zero-length move still reports completion.
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.abort_i) begin
                        // Abort beats a coincident step boundary: no advance, count frozen.
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sig   <= rest_sig(ph);
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt   <= '0;
                        ph        <= ph_stepped;
                        remaining <= remaining - STEPS_W'(1);
                        if (remaining == STEPS_W'(1)) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            sig   <= rest_sig(ph_stepped);
                        end else begin
                            sig <= coil(ph_stepped);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    sig   <= rest_sig(ph);
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    sig   <= rest_sig(ph);
                end
            endcase
        end
    end

    assign bus.busy_o      = busy;
    assign bus.done_o      = done;
    assign bus.remaining_o = remaining;
    assign bus.signal_o    = sig;
endmodule

// File: tb/tb_stepper_seq_driver.sv
// Bench for stepper_seq_driver: two instances (coils released / held at rest) fed identical stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_stepper_seq_driver;
    localparam int D  = 4;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [SW-1:0] steps_i = '0;
    logic          dir_i = 1'b0;
    logic          half_i = 1'b0;
    logic          abort_i = 1'b0;

    int checks = 0;
    int failures = 0;
    int ph_model = 0;

    logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                            4'b0010, 4'b0011, 4'b0001, 4'b1001};

    stepper_seq_driver_if #(.STEPS_W(SW)) bus0 ();
    stepper_seq_driver_if #(.STEPS_W(SW)) bus1 ();

    assign bus0.start_i = start_i;
    assign bus0.steps_i = steps_i;
    assign bus0.dir_i   = dir_i;
    assign bus0.half_i  = half_i;
    assign bus0.abort_i = abort_i;
    assign bus1.start_i = start_i;
    assign bus1.steps_i = steps_i;
    assign bus1.dir_i   = dir_i;
    assign bus1.half_i  = half_i;
    assign bus1.abort_i = abort_i;

    stepper_seq_driver #(.STEPS_W(SW), .STEP_DIV(D), .HOLD_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    stepper_seq_driver #(.STEPS_W(SW), .STEP_DIV(D), .HOLD_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    always #5 clk = ~clk;

    function automatic int mod8(input int x);
        return ((x % 8) + 8) % 8;
    endfunction

    // One move from IDLE. Expected trace comes from the move arithmetic:
    // cycle t of the run shows step j=(t-1)/D, i.e. phase ph0+s*j and count n-j.
    task automatic run_move(input string tag, input int n, input bit d, input bit h, input int abort_at);
        int s, run_len, taken, ph_end, j, busy_cnt, done_cnt, e_rem;
        logic [3:0] e_sig0, e_sig1;
        logic e_busy, e_done;
        s = h ? 1 : 2;
        if (!d) s = -s;
        run_len = (abort_at > 0) ? abort_at : n * D;
        taken   = (abort_at > 0) ? (abort_at - 1) / D : n;
        ph_end  = mod8(ph_model + s * taken);
        start_i = 1'b1;
        steps_i = SW'(n);
        dir_i   = d;
        half_i  = h;
        abort_i = 1'($urandom_range(0, 1));
        busy_cnt = 0;
        done_cnt = 0;
        for (int t = 1; t <= run_len + 2; t++) begin
            @(negedge clk);
            if (t <= run_len) begin
                j = (t - 1) / D;
                e_busy = 1'b1; e_done = 1'b0; e_rem = n - j;
                e_sig0 = tbl[mod8(ph_model + s * j)];
                e_sig1 = e_sig0;
            end else begin
                e_busy = 1'b0; e_done = (t == run_len + 1); e_rem = n - taken;
                e_sig0 = 4'b0000;
                e_sig1 = tbl[ph_end];
            end
            checks += 5;
            if ({bus0.busy_o, bus1.busy_o} !== {e_busy, e_busy}) begin
                failures++;
                $display("FAIL %s_busy t=%0d got %b%b want %b", tag, t, bus0.busy_o, bus1.busy_o, e_busy);
            end
            if ({bus0.done_o, bus1.done_o} !== {e_done, e_done}) begin
                failures++;
                $display("FAIL %s_done t=%0d got %b%b want %b", tag, t, bus0.done_o, bus1.done_o, e_done);
            end
            if (bus0.remaining_o !== SW'(e_rem) || bus1.remaining_o !== SW'(e_rem)) begin
                failures++;
                $display("FAIL %s_remaining t=%0d got %0d/%0d want %0d", tag, t, bus0.remaining_o, bus1.remaining_o, e_rem);
            end
            if (bus0.signal_o !== e_sig0) begin
                failures++;
                $display("FAIL %s_signal_release t=%0d got %b want %b", tag, t, bus0.signal_o, e_sig0);
            end
            if (bus1.signal_o !== e_sig1) begin
                failures++;
                $display("FAIL %s_signal_hold t=%0d got %b want %b", tag, t, bus1.signal_o, e_sig1);
            end
            busy_cnt += int'(bus0.busy_o);
            done_cnt += int'(bus0.done_o);
            // Start during DONE must be ignored; abort in DONE likewise; request inputs
            // scrambled while running must have no effect.
            start_i = (t == run_len + 1);
            abort_i = (t == abort_at) || ((t == run_len + 1) && ($urandom_range(0, 1) == 1));
            steps_i = SW'($urandom);
            dir_i   = 1'($urandom_range(0, 1));
            half_i  = 1'($urandom_range(0, 1));
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        checks += 2;
        if (busy_cnt != run_len) begin
            failures++;
            $display("FAIL %s_busy_cycles got %0d want %0d", tag, busy_cnt, run_len);
        end
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL %s_done_pulses got %0d want 1", tag, done_cnt);
        end
        ph_model = ph_end;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        checks += 2;
        if ({bus0.busy_o, bus0.done_o, bus0.remaining_o, bus0.signal_o} !== '0 ||
            {bus1.busy_o, bus1.done_o, bus1.remaining_o, bus1.signal_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got %b %b %0d %b / %b %b %0d %b want all zero",
                     bus0.busy_o, bus0.done_o, bus0.remaining_o, bus0.signal_o,
                     bus1.busy_o, bus1.done_o, bus1.remaining_o, bus1.signal_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (bus1.signal_o !== 4'b1000 || bus0.signal_o !== 4'b0000 || bus0.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_idle got hold=%b release=%b busy=%b want 1000 0000 0",
                     bus1.signal_o, bus0.signal_o, bus0.busy_o);
        end
        ph_model = 0;
    endtask

    task automatic test_full_step_fwd;
        run_move("full_fwd", 3, 1'b1, 1'b0, 0);
        checks++;
        if (bus1.signal_o !== 4'b0001) begin
            failures++;
            $display("FAIL full_fwd_final_phase got %b want 0001", bus1.signal_o);
        end
    endtask

    task automatic test_async_reset;
        start_i = 1'b1; steps_i = SW'(5); dir_i = 1'b1; half_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (6) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus0.busy_o, bus0.done_o, bus0.remaining_o, bus0.signal_o} !== '0 ||
            {bus1.busy_o, bus1.done_o, bus1.remaining_o, bus1.signal_o} !== '0) begin
            failures++;
            $display("FAIL async_reset_immediate got busy=%b rem=%0d sig=%b/%b want 0 0 0000",
                     bus0.busy_o, bus0.remaining_o, bus0.signal_o, bus1.signal_o);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus0.done_o !== 1'b0 || bus1.done_o !== 1'b0 || bus1.signal_o !== 4'b0000) begin
                failures++;
                $display("FAIL async_reset_hold got done=%b sig=%b want 0 0000", bus0.done_o, bus1.signal_o);
            end
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus1.signal_o !== 4'b1000 || bus0.done_o !== 1'b0 || bus0.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_release got sig=%b done=%b busy=%b want 1000 0 0",
                     bus1.signal_o, bus0.done_o, bus0.busy_o);
        end
        ph_model = 0;
    endtask

    task automatic test_half_rev_wrap;
        run_move("half_rev", 3, 1'b0, 1'b1, 0);
        checks++;
        if (bus1.signal_o !== 4'b0011) begin
            failures++;
            $display("FAIL half_rev_final_phase got %b want 0011", bus1.signal_o);
        end
    endtask

    task automatic test_zero_step;
        run_move("zero_step", 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    endtask

    task automatic test_abort_boundary;
        run_move("abort_boundary", 5, 1'b1, 1'b0, 2 * D);
        checks++;
        if (bus0.remaining_o !== SW'(4)) begin
            failures++;
            $display("FAIL abort_boundary_frozen got %0d want 4", bus0.remaining_o);
        end
    endtask

    task automatic test_continuous_hold;
        int s, ph0, p, m;
        logic e_busy, e_done;
        logic [3:0] e_sig;
        start_i = 1'b1; steps_i = SW'(1);
        dir_i = 1'($urandom_range(0, 1)); half_i = 1'($urandom_range(0, 1));
        s = half_i ? 1 : 2;
        if (!dir_i) s = -s;
        ph0 = ph_model;
        for (int t = 1; t <= 4 * (D + 2); t++) begin
            @(negedge clk);
            p = (t - 1) % (D + 2);
            m = (t - 1) / (D + 2);
            e_busy = (p < D);
            e_done = (p == D);
            e_sig  = (p < D) ? tbl[mod8(ph0 + s * m)] : tbl[mod8(ph0 + s * (m + 1))];
            checks += 2;
            if (bus1.busy_o !== e_busy || bus1.done_o !== e_done) begin
                failures++;
                $display("FAIL continuous_status t=%0d got busy=%b done=%b want %b %b",
                         t, bus1.busy_o, bus1.done_o, e_busy, e_done);
            end
            if (bus1.signal_o !== e_sig || bus1.signal_o === 4'b0000) begin
                failures++;
                $display("FAIL continuous_signal t=%0d got %b want %b", t, bus1.signal_o, e_sig);
            end
            if (t == 4 * (D + 2) - 1) start_i = 1'b0;
        end
        ph_model = mod8(ph0 + 4 * s);
    endtask

    task automatic test_random_moves;
        int n, a;
        for (int k = 0; k < 10; k++) begin
            n = int'($urandom_range(0, 5));
            a = 0;
            if (n > 0 && $urandom_range(0, 2) == 0) a = int'($urandom_range(1, n * D));
            run_move("random", n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a);
        end
    endtask

    initial begin
        test_reset();
        test_full_step_fwd();
        test_async_reset();
        test_half_rev_wrap();
        test_zero_step();
        test_abort_boundary();
        test_continuous_hold();
        test_random_moves();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stepper_seq_driver.md
# stepper_seq_driver

Parametrised 4-coil stepper motor driver for the cutter and feed axes. It moves a programmed number of steps in either direction, in full-step or half-step mode, at a rate set by a clock-cycle divider. It reports busy/done to the controller and supports abort. It sits between the mechanism controller and the coil drive pins, with `signal_o` wired straight to the motor driver board.

## Interface
- `STEPS_W`, 16: width of the step-count request and the remaining-count output.
- `STEP_DIV`, 10000: clk cycles per step (200 µs at 50 MHz). Minimum 2.
- `HOLD_EN`, 0: 1 keeps the last phase energised in IDLE; 0 drives coils to 4'b0000 in IDLE.

- `clk`, in, 1: system clock, single clock domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start_i`, in, 1: move request, sampled only in IDLE.
- `steps_i`, in, STEPS_W: number of steps to move, latched on accepted start.
- `dir_i`, in, 1: 1 = forward (phase index +), 0 = reverse; latched on start.
- `half_i`, in, 1: 1 = half-step (index ±1), 0 = full-step (index ±2); latched on start.
- `abort_i`, in, 1: terminate the move in progress.
- `busy_o`, out, 1: high in RUN.
- `done_o`, out, 1: one-cycle pulse at the end of every accepted move, whether completed, aborted or zero-length.
- `remaining_o`, out, STEPS_W: steps still to go.
- `signal_o`, out, 4: coil drive {A, B, C, D}.

## Operation
- **Phase table:** 3-bit index `ph`, wraps mod 8: 0:1000, 1:1100, 2:0100, 3:0110, 4:0010, 5:0011, 6:0001, 7:1001.
- **Position persistence:** `ph` persists across moves and is never reset except by `rst_n`.
- **Full-step behaviour:** full-step from an even `ph` gives single-coil wave drive; from an odd `ph` it gives two-coil drive.
- **States:** IDLE, RUN, DONE.
- **IDLE, `start_i`=1:** latch `steps_i`, `dir_i`, `half_i`.
  - `steps_i`≠0 → RUN, with the divider cleared to 0 and `remaining_o` = `steps_i`.
  - `steps_i`=0 → DONE, with no phase change.
- **RUN:**
  - `signal_o` = table[`ph`].
  - Divider counts 0..`STEP_DIV`-1.
  - At count `STEP_DIV`-1: `ph` ← `ph` ± (`half` ? 1 : 2) mod 8; `remaining` decrements; divider returns to 0.
  - When `remaining` goes 1→0 → DONE.
- **DONE:** `done_o`=1 for exactly one cycle, then → IDLE. `start_i` is ignored in DONE.
- **Abort:** `abort_i`=1 in RUN → DONE next cycle. The pending step is not taken and `remaining_o` freezes at its current value. If abort coincides with the step-boundary cycle, abort wins: no advance and no decrement. `abort_i` is ignored in IDLE and DONE.
- **Inputs after start:** `start_i` held high continuously starts a new move each time IDLE is re-entered. `steps_i`/`dir_i`/`half_i` changes during RUN have no effect.
- **Coil output in IDLE/DONE:** `signal_o` = `HOLD_EN` ? table[`ph`] : 4'b0000.
- **Reset (async, any state):** state IDLE, `ph`=0, divider 0, `remaining_o`=0, `busy_o`=0, `done_o`=0, `signal_o`=0000 (regardless of `HOLD_EN`, until the first IDLE cycle after reset). Any move in progress is discarded with no `done_o`.
- **Registered outputs:** all outputs are registered; no combinational path from inputs to outputs.

## Timing
- **Start to RUN:** start sampled at edge k → `busy_o`=1 and `signal_o` = table[`ph`] from edge k+1.
- **Step period:** each step occupies exactly `STEP_DIV` cycles. The new phase appears on `signal_o` the cycle after the boundary count.
- **N-step move:** `busy_o` is high for N·`STEP_DIV` cycles. `done_o` pulses in the cycle after `busy_o` falls. The earliest next start is sampled the cycle after `done_o`.
- **Zero-step request:** `done_o` pulses at k+1 and `busy_o` never rises.
- **Abort:** asserted at edge m in RUN → `busy_o`=0 and `done_o`=1 at m+1.
- **Remaining count:** `remaining_o` updates in the same cycle as the phase update.

## Test plan
- **Full-step forward:** reset, `STEP_DIV`=4, `HOLD_EN`=0, start `steps_i`=3, `dir_i`=1, `half_i`=0 → `signal_o` 1000, 0100, 0010, each held 4 cycles; `busy_o` high 12 cycles; `done_o` single pulse; then `signal_o`=0000 and `ph`=6.
- **Half-step reverse with wrap:** from `ph`=0, start 3 steps with `dir_i`=0, `half_i`=1 → `signal_o` 1000, 1001, 0001; final `ph`=5; `remaining_o` 3→2→1→0.
- **Zero-step request:** `steps_i`=0 → `done_o` pulse one cycle after start, `busy_o` stays 0, `ph` unchanged.
- **Abort on boundary:** abort on the boundary cycle of step 2 of 5 → no advance, `remaining_o`=4 frozen, `done_o` next cycle, `busy_o` falls the same cycle.
- **Hold mode, continuous start:** `HOLD_EN`=1, `start_i` held high, `steps_i`=1 → back-to-back moves separated by one DONE and one IDLE cycle; `signal_o` never 0000 after the first move.
- **Async reset mid-move:** `rst_n` low mid-move → `signal_o`=0000, `busy_o`=0, `remaining_o`=0 immediately (before the next clk edge), no `done_o`.
